// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: drains a show-ahead word FIFO into address-tagged bursts
// on a valid/ready port. Full bursts of BURST_LEN beats start when the FIFO's
// almost-empty flag is low. Defining DRAIN_FLUSH_EN adds a timeout flush that
// drains leftover words as single-beat bursts.
module fifo_burst_drain #(
  parameter int DATA_BIT_SIZE = 8,
  parameter int BURST_LEN     = 4,
  parameter int ADDR_BIT_SIZE = 16,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fifo_empty,
  input  logic                     fifo_A_empty,
  output logic                     fifo_read_en,
  input  logic [DATA_BIT_SIZE-1:0] fifo_read_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BIT_SIZE-1:0] out_data,
  output logic                     out_first,
  output logic                     out_last,
  output logic [ADDR_BIT_SIZE-1:0] out_addr,
  output logic [7:0]               out_len,
  output logic                     busy
);

  // Elaboration-time range checks on the configuration.
  if (BURST_LEN < 2 || BURST_LEN > 255) begin : g_bad_burst_len
    $error("fifo_burst_drain: BURST_LEN must be 2..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fifo_burst_drain: TIMEOUT must be 1..255");
  end

  typedef enum logic {S_IDLE, S_BURST} state_t;

  localparam logic [7:0] LP_BURST_LEN = 8'(BURST_LEN);

  state_t                   r_state, w_state_nxt;
  logic [7:0]               r_beat_cnt, w_beat_cnt_nxt;
  logic [7:0]               r_len, w_len_nxt;
  logic [ADDR_BIT_SIZE-1:0] r_addr, w_addr_nxt;
  logic                     w_busy, w_valid, w_handshake, w_last_beat;

`ifdef DRAIN_FLUSH_EN
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);
  logic [7:0] r_idle_cnt, w_idle_cnt_nxt;
`endif

  // Zero-latency datapath: the FIFO head is the beat on the wire.
  assign w_busy      = (r_state == S_BURST);
  assign w_valid     = w_busy && !fifo_empty;
  assign w_handshake = w_valid && out_ready;
  assign w_last_beat = (r_beat_cnt == r_len - 8'd1);

  assign busy         = w_busy;
  assign out_valid    = w_valid;
  assign out_data     = fifo_read_data;
  assign fifo_read_en = w_handshake;
  assign out_first    = w_valid && (r_beat_cnt == 8'd0);
  assign out_last     = w_valid && w_last_beat;
  assign out_addr     = r_addr;
  assign out_len      = r_len;

  // Next-state: burst launch from IDLE, beat counting and address advance in BURST.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_len_nxt      = r_len;
    w_addr_nxt     = r_addr;
`ifdef DRAIN_FLUSH_EN
    w_idle_cnt_nxt = r_idle_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (!fifo_A_empty) begin
          // A full burst is available; this wins over any pending flush.
          w_state_nxt    = S_BURST;
          w_len_nxt      = LP_BURST_LEN;
          w_beat_cnt_nxt = 8'd0;
`ifdef DRAIN_FLUSH_EN
          w_idle_cnt_nxt = 8'd0;
        end else if (!fifo_empty && r_idle_cnt == LP_TIMEOUT) begin
          // Partial FIFO sat idle long enough: drain one word on its own.
          w_state_nxt    = S_BURST;
          w_len_nxt      = 8'd1;
          w_beat_cnt_nxt = 8'd0;
          w_idle_cnt_nxt = 8'd0;
        end else if (fifo_empty) begin
          w_idle_cnt_nxt = 8'd0;
        end else if (r_idle_cnt != LP_TIMEOUT) begin
          w_idle_cnt_nxt = r_idle_cnt + 8'd1;
`endif
        end
      end
      S_BURST: begin
        if (w_handshake) begin
          if (w_last_beat) begin
            // Always pass through IDLE between bursts; address wraps silently.
            w_state_nxt = S_IDLE;
            w_addr_nxt  = r_addr + ADDR_BIT_SIZE'(r_len);
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 8'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State registers; reset abandons any partial burst immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= 8'd0;
      r_len      <= 8'd0;
      r_addr     <= '0;
`ifdef DRAIN_FLUSH_EN
      r_idle_cnt <= 8'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_len      <= w_len_nxt;
      r_addr     <= w_addr_nxt;
`ifdef DRAIN_FLUSH_EN
      r_idle_cnt <= w_idle_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain: bench for fifo_burst_drain. The bench models the
// upstream FIFO as a queue (almost-empty when fewer than BURST_LEN words) and
// keeps a burst-level reference of what the drain should present each cycle.
module tb_fifo_burst_drain;
  localparam int DW = 8, BL = 4, AW = 4, TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1, fifo_A_empty = 1'b1, fifo_read_en;
  logic [DW-1:0] fifo_read_data = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_first, out_last, busy;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_len;

  always #5 clk = ~clk;

  fifo_burst_drain #(.DATA_BIT_SIZE(DW), .BURST_LEN(BL), .ADDR_BIT_SIZE(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_A_empty(fifo_A_empty),
    .fifo_read_en(fifo_read_en), .fifo_read_data(fifo_read_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .out_addr(out_addr), .out_len(out_len), .busy(busy));

  int checks = 0, failures = 0;
  logic [7:0] q[$];           // upstream FIFO contents
  logic [7:0] beat_data[$];   // accepted beats, in order
  int first_addrs[$];         // base address of every burst seen
  // burst-level reference
  bit m_busy;
  int m_len, m_left, m_base, m_idle;

  typedef struct {
    bit          wr;
    logic [7:0]  wd;
    bit          rdy;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic v, rd, f, l, b, input logic [7:0] d,
                                     input logic [3:0] a, input logic [7:0] len);
    return {7'd0, v, rd, f, l, b, (v ? d : 8'd0), a, len};
  endfunction

  function automatic logic [31:0] act_pk();
    return pk(out_valid, fifo_read_en, out_first, out_last, busy, out_data, out_addr, out_len);
  endfunction

  task automatic drive_fifo();
    fifo_empty     = (q.size() == 0);
    fifo_A_empty   = (q.size() < BL);
    fifo_read_data = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // Called after the mid-cycle sample: clock edge, then FIFO pop/push.
  task automatic commit(input bit wr, input logic [7:0] wd);
    logic rd;
    rd = fifo_read_en;
    @(posedge clk); #1;
    if (rd && q.size() != 0) void'(q.pop_front());
    if (wr) q.push_back(wd);
    drive_fifo();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    q.delete();
    drive_fifo();
    #1;
    chk("reset_state", act_pk(), pk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'd0));
    m_busy = 0; m_len = 0; m_left = 0; m_base = 0; m_idle = 0;
    beat_data.delete();
    first_addrs.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive_fifo();
  endtask

  task automatic m_start(input int len);
    m_busy = 1; m_len = len; m_left = len; m_idle = 0;
  endtask

  // One cycle checked against the burst-level reference.
  task automatic mcycle(input bit wr, input logic [7:0] wd, input bit rdy);
    logic ev, ef, el;
    int n;
    out_ready = rdy;
    @(negedge clk);
    n  = q.size();
    ev = m_busy && n > 0;
    ef = ev && (m_left == m_len);
    el = ev && (m_left == 1);
    chk("model", act_pk(), pk(ev, ev && rdy, ef, el, m_busy, (n != 0) ? q[0] : 8'h00,
                              4'(m_base), 8'(m_len)));
    if (ev && rdy) begin
      beat_data.push_back(q[0]);
      if (ef) first_addrs.push_back(m_base);
    end
    if (m_busy) begin
      if (ev && rdy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_base = (m_base + m_len) % (1 << AW);
        end
      end
    end else if (n >= BL) begin
      m_start(BL);
`ifdef DRAIN_FLUSH_EN
    end else if (n > 0 && m_idle == TO) begin
      m_start(1);
    end else if (n == 0) begin
      m_idle = 0;
    end else if (m_idle < TO) begin
      m_idle++;
`endif
    end
    commit(wr, wd);
  endtask

  initial begin
    int exp_wrap[5];
    bit found;

    // Directed vectors: four words in, one full burst out.
    tbl[0] = '{1, 8'hA0, 1, pk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'd0)};
    tbl[1] = '{1, 8'hA1, 1, pk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'd0)};
    tbl[2] = '{1, 8'hA2, 1, pk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'd0)};
    tbl[3] = '{1, 8'hA3, 1, pk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'd0)};
    tbl[4] = '{0, 8'h00, 1, pk(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'd0)};
    tbl[5] = '{0, 8'h00, 1, pk(1, 1, 1, 0, 1, 8'hA0, 4'd0, 8'd4)};
    tbl[6] = '{0, 8'h00, 1, pk(1, 1, 0, 0, 1, 8'hA1, 4'd0, 8'd4)};
    tbl[7] = '{0, 8'h00, 1, pk(1, 1, 0, 0, 1, 8'hA2, 4'd0, 8'd4)};
    tbl[8] = '{0, 8'h00, 1, pk(1, 1, 0, 1, 1, 8'hA3, 4'd0, 8'd4)};
    tbl[9] = '{0, 8'h00, 1, pk(0, 0, 0, 0, 0, 8'h00, 4'd4, 8'd4)};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d", i), act_pk(), tbl[i].exp);
      commit(tbl[i].wr, tbl[i].wd);
    end

    // Eight words with out_ready toggling: two bursts, order preserved.
    do_reset();
    for (int i = 0; i < 8; i++) mcycle(1, 8'(8'h10 + i), (i % 2) == 0);
    for (int i = 0; i < 40; i++) mcycle(0, 8'h00, (i % 2) == 0);
    chk("toggle_beats", 32'(beat_data.size()), 32'd8);
    for (int i = 0; i < 8 && i < beat_data.size(); i++)
      chk($sformatf("toggle_data%0d", i), 32'(beat_data[i]), 32'(8'h10 + i));
    chk("toggle_bursts", 32'(first_addrs.size()), 32'd2);
    if (first_addrs.size() == 2) chk("toggle_addr2", 32'(first_addrs[1]), 32'd4);

`ifdef DRAIN_FLUSH_EN
    // One lone word is flushed as a single-beat burst after the timeout.
    do_reset();
    mcycle(1, 8'h5A, 1);
    for (int i = 0; i < 30; i++) mcycle(0, 8'h00, 1);
    chk("flush_beats", 32'(beat_data.size()), 32'd1);
    if (beat_data.size() == 1) chk("flush_data", 32'(beat_data[0]), 32'h5A);
    @(negedge clk);
    chk("flush_addr", 32'(out_addr), 32'd1);
    chk("flush_len", 32'(out_len), 32'd1);
    commit(0, 8'h00);
`else
    // Three words never form a burst; a fourth releases a full burst.
    do_reset();
    for (int i = 0; i < 3; i++) mcycle(1, 8'(8'h30 + i), 1);
    for (int i = 0; i < 100; i++) mcycle(0, 8'h00, 1);
    chk("partial_waits", 32'(beat_data.size()), 32'd0);
    mcycle(1, 8'h33, 1);
    for (int i = 0; i < 10; i++) mcycle(0, 8'h00, 1);
    chk("partial_burst", 32'(beat_data.size()), 32'd4);
    if (beat_data.size() == 4) chk("partial_last", 32'(beat_data[3]), 32'h33);
`endif

    // Five full bursts with a 4-bit address: 0,4,8,12 then wrap to 0.
    do_reset();
    exp_wrap = '{0, 4, 8, 12, 0};
    for (int i = 0; i < 20; i++) mcycle(1, 8'(i), 1);
    for (int i = 0; i < 40; i++) mcycle(0, 8'h00, 1);
    chk("wrap_bursts", 32'(first_addrs.size()), 32'd5);
    for (int i = 0; i < 5 && i < first_addrs.size(); i++)
      chk($sformatf("wrap_addr%0d", i), 32'(first_addrs[i]), 32'(exp_wrap[i]));

    // Reset asserted on the second beat of a burst.
    do_reset();
    for (int i = 0; i < 4; i++) mcycle(1, 8'(8'hC0 + i), 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_first) found = 1;
      commit(0, 8'h00);
    end
    chk("reach_burst", 32'(found), 32'd1);
    @(negedge clk);
    chk("beat2_live", {30'd0, out_valid, fifo_read_en}, 32'd3);
    reset = 1'b1;
    #1;
    chk("rst_drop", {30'd0, out_valid, fifo_read_en}, 32'd0);
    q.delete();
    drive_fifo();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after", {27'd0, busy, out_addr}, 32'd0);

    // Randomized traffic against the reference.
    do_reset();
    for (int i = 0; i < 3000; i++)
      mcycle(($urandom_range(2) != 0) && (q.size() < 12), 8'($urandom), $urandom_range(3) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
